// File: rtl/pid_chan_ctrl.sv
// pid_chan_ctrl: parametrised single-channel PID controller with limits and anti-windup
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   dat_i, dat_vld_i           measured sample (signed) and its valid strobe
//   set_sp_i                   set point
//   set_kp_i/ki_i/kd_i         P/I/D gains (signed)
//   set_lim_hi_i/lo_i          output limits (signed)
//   int_rst_i, int_hold_i      integrator + derivative history clear, integrator freeze
//   dat_o, dat_vld_o           controller output and 1-cycle update strobe (4 cycles after dat_vld_i)
//   sat_o, int_sat_o           output clamped flag, integrator clamped flag
module pid_chan_ctrl #(
    parameter int DW  = 14,
    parameter int KW  = 14,
    parameter int IW  = 32,
    parameter int PSR = 12,
    parameter int ISR = 10,
    parameter int DSR = 10
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] dat_i,
    input  logic          dat_vld_i,
    input  logic [DW-1:0] set_sp_i,
    input  logic [KW-1:0] set_kp_i,
    input  logic [KW-1:0] set_ki_i,
    input  logic [KW-1:0] set_kd_i,
    input  logic [DW-1:0] set_lim_hi_i,
    input  logic [DW-1:0] set_lim_lo_i,
    input  logic          int_rst_i,
    input  logic          int_hold_i,
    output logic [DW-1:0] dat_o,
    output logic          dat_vld_o,
    output logic          sat_o,
    output logic          int_sat_o
);
    localparam int PW = DW + KW + 1;
    localparam int SW = (IW > PW + 1 ? IW : PW + 1) + 2;

    function automatic logic signed [PW-1:0] mul(input logic [DW:0] a, input logic [KW-1:0] b);
        logic signed [PW-1:0] ax, bx;
        ax = {{KW{a[DW]}}, a};
        bx = {{(DW + 1){b[KW-1]}}, b};
        return ax * bx;
    endfunction

    logic                 v1, v2, v3;
    logic signed [DW:0]   err;
    logic signed [PW-1:0] pp, pi, pd, kd_prev, p;
    logic signed [PW:0]   d, pd_diff;
    logic signed [IW-1:0] int_acc;

    logic signed [IW:0]   int_sum;
    logic signed [IW-1:0] int_sat_val, t_sel, t_sh, hi_w, lo_w, int_nxt;
    logic                 int_hi, int_lo;
    logic signed [SW-1:0] p_x, i_x, d_x, sum, hi_x, lo_x, hi_c;
    logic                 over, under;
    logic [DW-1:0]        dat_nxt;

    assign pd_diff = $signed({pd[PW-1], pd}) - $signed({kd_prev[PW-1], kd_prev});

    // Integrator: add with saturation to IW bits, then anti-windup against the output limits
    assign int_sum     = $signed({int_acc[IW-1], int_acc}) + $signed({{(IW + 1 - PW){pi[PW-1]}}, pi});
    assign int_sat_val = (int_sum[IW] != int_sum[IW-1])
                         ? (int_sum[IW] ? {1'b1, {(IW - 1){1'b0}}} : {1'b0, {(IW - 1){1'b1}}})
                         : int_sum[IW-1:0];
    assign t_sel       = int_hold_i ? int_acc : int_sat_val;
    assign t_sh        = t_sel >>> ISR;
    assign hi_w        = {{(IW - DW){set_lim_hi_i[DW-1]}}, set_lim_hi_i};
    assign lo_w        = {{(IW - DW){set_lim_lo_i[DW-1]}}, set_lim_lo_i};
    assign int_hi      = t_sh > hi_w;
    assign int_lo      = t_sh < lo_w;
    assign int_nxt     = int_hi ? (hi_w <<< ISR) : int_lo ? (lo_w <<< ISR) : t_sel;

    // Output sum is wide enough that no term can wrap; upper clamp first so lim_lo wins when inverted
    assign p_x     = {{(SW - PW){p[PW-1]}}, p};
    assign i_x     = {{(SW - IW){int_acc[IW-1]}}, int_acc >>> ISR};
    assign d_x     = {{(SW - PW - 1){d[PW]}}, d};
    assign sum     = p_x + i_x + d_x;
    assign hi_x    = {{(SW - DW){set_lim_hi_i[DW-1]}}, set_lim_hi_i};
    assign lo_x    = {{(SW - DW){set_lim_lo_i[DW-1]}}, set_lim_lo_i};
    assign over    = sum > hi_x;
    assign hi_c    = over ? hi_x : sum;
    assign under   = hi_c < lo_x;
    assign dat_nxt = under ? set_lim_lo_i : over ? set_lim_hi_i : sum[DW-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            dat_vld_o <= 1'b0;
            err       <= '0;
            pp        <= '0;
            pi        <= '0;
            pd        <= '0;
            p         <= '0;
            d         <= '0;
            kd_prev   <= '0;
            int_acc   <= '0;
            int_sat_o <= 1'b0;
            dat_o     <= '0;
            sat_o     <= 1'b0;
        end else begin
            v1        <= dat_vld_i;
            v2        <= v1;
            v3        <= v2;
            dat_vld_o <= v3;
            if (dat_vld_i)
                err <= $signed({set_sp_i[DW-1], set_sp_i}) - $signed({dat_i[DW-1], dat_i});
            if (v1) begin
                pp <= mul(err, set_kp_i);
                pi <= mul(err, set_ki_i);
                pd <= mul(err, set_kd_i);
            end
            if (v2)
                p <= pp >>> PSR;
            // The clear acts on every cycle, not only on qualified samples
            if (int_rst_i) begin
                int_acc   <= '0;
                kd_prev   <= '0;
                d         <= '0;
                int_sat_o <= 1'b0;
            end else if (v2) begin
                d         <= pd_diff >>> DSR;
                kd_prev   <= pd;
                int_acc   <= int_nxt;
                int_sat_o <= int_hi | int_lo;
            end
            if (v3) begin
                dat_o <= dat_nxt;
                sat_o <= under ? (lo_x != sum) : over;
            end
        end
    end
endmodule

// File: tb/tb_pid_chan_ctrl.sv
// tb_pid_chan_ctrl: directed vector bench for pid_chan_ctrl
module tb_pid_chan_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstn_i;
    logic signed [13:0] dat_i, set_sp_i, set_kp_i, set_ki_i, set_kd_i, set_lim_hi_i, set_lim_lo_i;
    logic               dat_vld_i, int_rst_i, int_hold_i;
    logic signed [13:0] dat_o;
    logic               dat_vld_o, sat_o, int_sat_o;

    pid_chan_ctrl dut (
        .clk_i(clk), .rstn_i(rstn_i), .dat_i(dat_i), .dat_vld_i(dat_vld_i),
        .set_sp_i(set_sp_i), .set_kp_i(set_kp_i), .set_ki_i(set_ki_i), .set_kd_i(set_kd_i),
        .set_lim_hi_i(set_lim_hi_i), .set_lim_lo_i(set_lim_lo_i),
        .int_rst_i(int_rst_i), .int_hold_i(int_hold_i),
        .dat_o(dat_o), .dat_vld_o(dat_vld_o), .sat_o(sat_o), .int_sat_o(int_sat_o)
    );

    typedef struct {
        int sp, dat, kp, ki, kd, hi, lo;
        bit clr, hold;
        int e_dat;
        bit e_sat, e_isat;
    } vec_t;

    vec_t tv[20];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(int sp, int dat, int kp, int ki, int kd, int hi, int lo,
                                bit clr, bit hold, int e_dat, bit e_sat, bit e_isat);
        vec_t r;
        r.sp = sp; r.dat = dat; r.kp = kp; r.ki = ki; r.kd = kd; r.hi = hi; r.lo = lo;
        r.clr = clr; r.hold = hold; r.e_dat = e_dat; r.e_sat = e_sat; r.e_isat = e_isat;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int sp, input int dat, input int kp, input int ki, input int kd,
                           input int hi, input int lo);
        set_sp_i = 14'(sp); dat_i = 14'(dat); set_kp_i = 14'(kp); set_ki_i = 14'(ki);
        set_kd_i = 14'(kd); set_lim_hi_i = 14'(hi); set_lim_lo_i = 14'(lo);
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        bit got;
        @(negedge clk);
        set_cfg(t.sp, t.dat, t.kp, t.ki, t.kd, t.hi, t.lo);
        int_rst_i  = t.clr;
        int_hold_i = t.hold;
        dat_vld_i  = 1'b1;
        @(negedge clk);
        dat_vld_i = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (dat_vld_o) got = 1'b1;
        end
        chk($sformatf("v%0d_vld", idx), int'(got), 1);
        if (got) begin
            chk($sformatf("v%0d_dat", idx), int'(dat_o), t.e_dat);
            chk($sformatf("v%0d_sat", idx), int'(sat_o), int'(t.e_sat));
            chk($sformatf("v%0d_isat", idx), int'(int_sat_o), int'(t.e_isat));
        end
        int_rst_i  = 1'b0;
        int_hold_i = 1'b0;
    endtask

    initial begin
        int vals[4];
        int cyc[4];
        int n;
        tv[0]  = mk(1000, 0, 4096, 0, 0, 8191, -8191, 1, 0, 1000, 0, 0);
        tv[1]  = mk(1000, 1500, 4096, 0, 0, 8191, -8191, 0, 0, -500, 0, 0);
        tv[2]  = mk(100, 0, 0, 1024, 0, 8191, -8191, 1, 0, 0, 0, 0);
        tv[3]  = mk(100, 0, 0, 1024, 0, 8191, -8191, 0, 0, 100, 0, 0);
        tv[4]  = mk(100, 0, 0, 1024, 0, 8191, -8191, 0, 0, 200, 0, 0);
        tv[5]  = mk(100, 0, 0, 1024, 0, 250, -8191, 0, 0, 250, 0, 1);
        tv[6]  = mk(100, 0, 0, 1024, 0, 250, -8191, 0, 0, 250, 0, 1);
        tv[7]  = mk(-100, 0, 0, 1024, 0, 250, -8191, 0, 0, 150, 0, 0);
        tv[8]  = mk(100, 0, 0, 1024, 0, 8191, -8191, 0, 0, 250, 0, 0);
        tv[9]  = mk(100, 0, 0, 1024, 0, 8191, -8191, 0, 0, 350, 0, 0);
        tv[10] = mk(100, 0, 0, 1024, 0, 8191, -8191, 0, 1, 350, 0, 0);
        tv[11] = mk(100, 0, 0, 1024, 0, 8191, -8191, 1, 0, 0, 0, 0);
        tv[12] = mk(0, 0, 0, 0, 1024, 8191, -8191, 1, 0, 0, 0, 0);
        tv[13] = mk(200, 0, 0, 0, 1024, 8191, -8191, 0, 0, 200, 0, 0);
        tv[14] = mk(200, 0, 0, 0, 1024, 8191, -8191, 0, 0, 0, 0, 0);
        tv[15] = mk(7000, -8192, -3000, 0, 0, 8191, -500, 1, 0, -500, 1, 0);
        tv[16] = mk(3000, 0, 4096, 0, 0, 2000, -8191, 0, 0, 2000, 1, 0);
        tv[17] = mk(0, 0, 4096, 0, 0, -100, 100, 0, 0, 100, 1, 1);
        tv[18] = mk(0, 1, 1, 0, 0, 8191, -8191, 1, 0, -1, 0, 0);
        tv[19] = mk(1, 0, 1, 0, 0, 8191, -8191, 0, 0, 0, 0, 0);

        rstn_i = 1'b0; dat_vld_i = 1'b0; int_rst_i = 1'b0; int_hold_i = 1'b0;
        set_cfg(1000, 0, 4096, 0, 0, 8191, -8191);
        repeat (3) @(negedge clk);
        chk("rst_dat", int'(dat_o), 0);
        chk("rst_vld", int'(dat_vld_o), 0);
        chk("rst_sat", int'(sat_o), 0);
        chk("rst_isat", int'(int_sat_o), 0);
        rstn_i = 1'b1;

        // Exact latency: strobe seen at one edge, dat_vld_o visible only after the third edge after it
        @(negedge clk);
        dat_vld_i = 1'b1;
        @(negedge clk);
        dat_vld_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("lat_vld_c%0d", c), int'(dat_vld_o), c == 4 ? 1 : 0);
            if (c == 4) chk("lat_dat", int'(dat_o), 1000);
            @(negedge clk);
        end

        for (int i = 0; i < 20; i++) run_vec(tv[i], i);

        // Back-to-back integration, one output per cycle
        @(negedge clk);
        set_cfg(100, 0, 0, 1024, 0, 8191, -8191);
        int_rst_i = 1'b1;
        @(negedge clk);
        int_rst_i = 1'b0;
        dat_vld_i = 1'b1;
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (dat_vld_o && n < 4) begin
                vals[n] = int'(dat_o);
                cyc[n]  = c;
                n++;
            end
            if (c == 4) dat_vld_i = 1'b0;
        end
        chk("b2b_count", n, 4);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("b2b_dat%0d", i), vals[i], 100 * (i + 1));
            chk($sformatf("b2b_cyc%0d", i), cyc[i], 4 + i);
        end

        // Asynchronous reset while a sample is at v2 discards it
        @(negedge clk);
        set_cfg(1000, 0, 4096, 0, 0, 8191, -8191);
        dat_vld_i = 1'b1;
        @(negedge clk);
        dat_vld_i = 1'b0;
        @(posedge clk);
        #1 rstn_i = 1'b0;
        #1;
        chk("arst_dat", int'(dat_o), 0);
        chk("arst_vld", int'(dat_vld_o), 0);
        chk("arst_sat", int'(sat_o), 0);
        chk("arst_isat", int'(int_sat_o), 0);
        @(negedge clk);
        rstn_i = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dat_vld_o) n++;
        end
        chk("arst_no_vld", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pid_chan_ctrl.md
Name: pid_chan_ctrl

Overview:
Parametrised single-channel PID controller. It is the successor to the fixed 14-bit MIMO PID section, and the MIMO wrapper instantiates one per input/output pair. It adds several features:
- generic data, gain and shift widths
- a per-sample valid qualifier
- programmable output limits
- integrator anti-windup clamping
- an integrator hold input
- saturation status flags

It sits between the ADC input path and the DAC output mux. All settings come from the register bank.

Parameters:
DW, 14, ADC/DAC sample width (signed)
KW, 14, width of each gain Kp/Ki/Kd (signed)
IW, 32, integrator accumulator width (signed)
PSR, 12, right shift applied to P product (Kp=2^PSR is unity gain)
ISR, 10, right shift applied to integrator (Ki=2^ISR adds the error once per sample)
DSR, 10, right shift applied to D difference

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
dat_i  in  DW  measured value, signed
dat_vld_i  in  1  dat_i valid strobe
set_sp_i  in  DW  set point, signed
set_kp_i  in  KW  proportional gain, signed
set_ki_i  in  KW  integral gain, signed
set_kd_i  in  KW  derivative gain, signed
set_lim_hi_i  in  DW  upper output limit, signed
set_lim_lo_i  in  DW  lower output limit, signed
int_rst_i  in  1  synchronous integrator + derivative history clear
int_hold_i  in  1  freeze integrator
dat_o  out  DW  controller output, signed
dat_vld_o  out  1  dat_o updated strobe
sat_o  out  1  last dat_o was clamped to a limit
int_sat_o  out  1  integrator is held at a limit clamp

Behaviour:
- Reset: all pipeline registers, int_acc, kd_prev, dat_o, dat_vld_o, sat_o and int_sat_o are 0. Reset mid-pipeline discards in-flight samples.
- All arithmetic is signed two's complement. Shifts are arithmetic; no rounding (truncate toward -inf).
- The pipeline advances only for qualified samples. Stage valids are v1..v4, each a 1-cycle pulse. Latency is fixed: dat_vld_o is high exactly 4 cycles after the dat_vld_i edge. A new sample may be accepted every cycle.
- S1 (dat_vld_i): err <= set_sp_i - dat_i, DW+1 bits, no overflow possible.
- S2 (v1): pp <= err*kp; pi <= err*ki; pd <= err*kd. Each product is DW+KW+1 bits.
- S3 (v2):
  - p <= pp>>>PSR.
  - d <= (pd - kd_prev)>>>DSR, then kd_prev <= pd.
  - Integrator update, in priority order:
    - int_rst_i: int_acc <= 0, kd_prev <= 0, d <= 0.
    - else int_hold_i: int_acc is unchanged.
    - else: t = int_acc + pi, saturated to IW bits.
  - Anti-windup on the integrator result:
    - if (t>>>ISR) > lim_hi: int_acc <= lim_hi<<<ISR and int_sat_o <= 1.
    - else if (t>>>ISR) < lim_lo: int_acc <= lim_lo<<<ISR and int_sat_o <= 1.
    - else int_acc <= t and int_sat_o <= 0.
  - int_rst_i and int_hold_i are sampled on the v2 cycle.
  - int_rst_i applies even without v2 (the clear is immediate) and wins over hold.
- S4 (v3):
  - sum = p + (int_acc>>>ISR) + d. Sum width is wide enough that no internal wrap is possible.
  - dat_o <= sum clamped to [lim_lo, lim_hi]. The upper clamp is applied first, then the lower, so lim_lo wins if lim_hi < lim_lo.
  - sat_o <= 1 iff a clamp changed the value. dat_o and sat_o hold between samples.
- Settings are sampled combinationally at the stage that uses them. A mid-pipeline change affects only the stages not yet executed.

Test Plan:
- P only: kp=4096, ki=kd=0, sp=1000, lim ±8191, one dat_i=0 strobe -> dat_vld_o 4 cycles later, dat_o=1000, sat_o=0. With dat_i=1500: dat_o=-500.
- Integrator: ki=1024, kp=kd=0, sp=100, dat_i=0, strobes every cycle -> dat_o=100,200,300,... with one new value per cycle after 4-cycle latency.
- Anti-windup: same settings with lim_hi=250 -> dat_o=100,200,250,250 and int_sat_o=1 from the 3rd sample. Then sp=-100 -> next dat_o=150 (not 250+), and int_sat_o=0.
- Derivative: kd=1024, kp=ki=0, sp steps 0->200 with dat_i=0 -> dat_o=200 for one sample, then 0. Hold and reset: after integrating to 300, int_hold_i=1 -> output stays 300; int_rst_i=1 -> next output 0.
- Limits and reset: kp=-3000, sp=7000, dat_i=-8192 with lim_lo=-500 -> dat_o=-500, sat_o=1. Assert rstn_i=0 while v2 is in flight -> all outputs 0 immediately; no dat_vld_o follows release.
